arch_state_dumper: RTL and testbench



---
 rtl/core_dbg_pkg.sv | 30 +++
 rtl/dump_slot.sv | 26 ++
 rtl/arch_state_dumper.sv | 144 ++++++++++++++
 tb/tb_arch_state_dumper.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_dbg_pkg.sv
// Shared debug-dump types: dumper FSM states and the item carried on the dump port.
package core_dbg_pkg;

    localparam int unsigned DUMP_IDX_W      = 3;
    localparam int unsigned DUMP_DATA_MAX_W = 64;

    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        REG    = 3'd2,
        MEM    = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } dump_state_e;

    // Data field sized for the widest supported word; users narrow it to DATA_W.
    typedef struct packed {
        logic                       kind;
        logic [DUMP_IDX_W-1:0]      index;
        logic [DUMP_DATA_MAX_W-1:0] data;
    } dump_item_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dump_slot.sv
// One-entry valid/ready output register; a push is only issued when the slot is free.
module dump_slot
    import core_dbg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  dump_item_t push_item,
    input  logic       ready,
    output logic       valid,
    output dump_item_t item
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            item  <= '0;
        end else if (push) begin
            valid <= 1'b1;
            item  <= push_item;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/arch_state_dumper.sv
// After a halt, streams every architectural register (via SRAT->PRF) and then the
// data-memory words out of a valid/ready port, then reports completion until reset.
module arch_state_dumper
    import core_dbg_pkg::*;
#(
    parameter int unsigned NUM_AREG   = 8,
    parameter int unsigned NUM_MEM    = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned PREG_W     = 5,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        halt,
    output logic [$clog2(NUM_AREG)-1:0] srat_rd_idx,
    input  logic [PREG_W-1:0]           srat_rd_preg,
    output logic [PREG_W-1:0]           prf_rd_idx,
    input  logic [DATA_W-1:0]           prf_rd_data,
    output logic [$clog2(NUM_MEM)-1:0]  mem_rd_addr,
    input  logic [DATA_W-1:0]           mem_rd_data,
    output logic                        dump_valid,
    input  logic                        dump_ready,
    output logic                        dump_kind,
    output logic [2:0]                  dump_index,
    output logic [DATA_W-1:0]           dump_data,
    output logic                        busy,
    output logic                        dump_done
);

    localparam int unsigned AREG_W = $clog2(NUM_AREG);
    localparam int unsigned MEM_W  = $clog2(NUM_MEM);
    localparam int unsigned IDX_W  = $clog2(max_u(NUM_AREG, NUM_MEM));
    localparam int unsigned CNT_W  = $clog2(SETTLE_CYC + 1);

    dump_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               slot_free_c;
    logic               push_c;
    dump_item_t         push_item_c;
    dump_item_t         slot_item;

    assign slot_free_c = !dump_valid || dump_ready;

    // Read ports are only driven while the matching phase is active.
    assign srat_rd_idx = (state_q == REG) ? AREG_W'(idx_q) : '0;
    assign prf_rd_idx  = (state_q == REG) ? srat_rd_preg   : '0;
    assign mem_rd_addr = (state_q == MEM) ? MEM_W'(idx_q)  : '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        push_c      = 1'b0;
        push_item_c = '0;
        unique case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                    idx_d   = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = REG;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            REG: begin
                if (slot_free_c) begin
                    push_c            = 1'b1;
                    push_item_c.kind  = KIND_REG;
                    push_item_c.index = DUMP_IDX_W'(idx_q);
                    push_item_c.data  = DUMP_DATA_MAX_W'(prf_rd_data);
                    if (idx_q == IDX_W'(NUM_AREG - 1)) begin
                        state_d = MEM;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            MEM: begin
                if (slot_free_c) begin
                    push_c            = 1'b1;
                    push_item_c.kind  = KIND_MEM;
                    push_item_c.index = DUMP_IDX_W'(idx_q);
                    push_item_c.data  = DUMP_DATA_MAX_W'(mem_rd_data);
                    if (idx_q == IDX_W'(NUM_MEM - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (dump_valid && dump_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            busy      <= 1'b0;
            dump_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            busy      <= (state_d == SETTLE) || (state_d == REG) ||
                         (state_d == MEM)    || (state_d == DRAIN);
            dump_done <= (state_d == DONE);
        end
    end

    dump_slot u_slot (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_item (push_item_c),
        .ready     (dump_ready),
        .valid     (dump_valid),
        .item      (slot_item)
    );

    assign dump_kind  = slot_item.kind;
    assign dump_index = slot_item.index;
    assign dump_data  = DATA_W'(slot_item.data);

endmodule

// File: tb/tb_arch_state_dumper.sv
// Bench for arch_state_dumper: expected item stream derived from SRAT/PRF/memory tables.
module tb_arch_state_dumper;

    logic        clk;
    logic        rst;
    logic        halt;
    logic [2:0]  srat_rd_idx;
    logic [4:0]  srat_rd_preg;
    logic [4:0]  prf_rd_idx;
    logic [15:0] prf_rd_data;
    logic [1:0]  mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        dump_valid;
    logic        dump_ready;
    logic        dump_kind;
    logic [2:0]  dump_index;
    logic [15:0] dump_data;
    logic        busy;
    logic        dump_done;

    logic [4:0]  srat_tab [8];
    logic [15:0] prf_tab  [32];
    logic [15:0] mem_tab  [4];

    int n_vec = 0;
    int n_err = 0;

    arch_state_dumper dut (
        .clk          (clk),
        .rst          (rst),
        .halt         (halt),
        .srat_rd_idx  (srat_rd_idx),
        .srat_rd_preg (srat_rd_preg),
        .prf_rd_idx   (prf_rd_idx),
        .prf_rd_data  (prf_rd_data),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_kind    (dump_kind),
        .dump_index   (dump_index),
        .dump_data    (dump_data),
        .busy         (busy),
        .dump_done    (dump_done)
    );

    assign srat_rd_preg = srat_tab[srat_rd_idx];
    assign prf_rd_data  = prf_tab[prf_rd_idx];
    assign mem_rd_data  = mem_tab[mem_rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_item(input logic k, input logic [2:0] i, input logic [15:0] d);
        return 64'({k, i, d});
    endfunction

    function automatic logic [63:0] dut_item();
        return pack_item(dump_kind, dump_index, dump_data);
    endfunction

    task automatic do_reset();
        rst        = 1'b0;
        halt       = 1'b0;
        dump_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // mode 0: ready held 1; 1: ready toggles 1,0,1,0; 2: random; 3: 20-cycle stall on first item
    task automatic run_dump(input string name, input int mode, input bit extra_halt);
        logic [63:0] exp_q [$];
        logic [63:0] held;
        bit          hold;
        bit          first_seen;
        bit          last_popped;
        bit          finished;
        bit          halt_sent;
        int          stall_left;

        for (int r = 0; r < 8; r++) exp_q.push_back(pack_item(1'b0, 3'(r), prf_tab[srat_tab[r]]));
        for (int m = 0; m < 4; m++) exp_q.push_back(pack_item(1'b1, 3'(m), mem_tab[m]));

        hold = 0; first_seen = 0; last_popped = 0; finished = 0; halt_sent = 0;
        stall_left = 20;
        held = '0;
        dump_ready = 1'b1;
        halt = 1'b1;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            halt = 1'b0;
            if (i == 1) chk({name, "_busy_after_halt"}, 64'(busy), 64'd1);
            if (last_popped) begin
                chk({name, "_done"}, 64'(dump_done), 64'd1);
                chk({name, "_busy_done"}, 64'(busy), 64'd0);
                chk({name, "_valid_done"}, 64'(dump_valid), 64'd0);
                finished = 1;
                break;
            end
            if (hold) begin
                chk({name, "_hold_valid"}, 64'(dump_valid), 64'd1);
                chk({name, "_hold_item"}, dut_item(), held);
                if (mode == 3) chk({name, "_busy_stall"}, 64'(busy), 64'd1);
            end
            if (dump_valid && !first_seen) begin
                first_seen = 1;
                chk({name, "_first_valid_lat"}, 64'(i), 64'd6);
            end
            if (extra_halt && !halt_sent && dump_valid && !dump_kind && dump_index == 3'd3) begin
                halt = 1'b1;
                halt_sent = 1;
            end
            case (mode)
                0: dump_ready = 1'b1;
                1: dump_ready = (i == 1) ? 1'b1 : ~dump_ready;
                2: dump_ready = 1'($urandom_range(1, 0));
                default: begin
                    if (first_seen && stall_left > 0) begin
                        dump_ready = 1'b0;
                        stall_left--;
                    end else begin
                        dump_ready = 1'b1;
                    end
                end
            endcase
            hold = 0;
            if (dump_valid && dump_ready) begin
                if (exp_q.size() == 0) begin
                    chk({name, "_extra_item"}, dut_item(), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk({name, "_item"}, dut_item(), exp_q.pop_front());
                    if (exp_q.size() == 0) last_popped = 1;
                end
            end else if (dump_valid) begin
                hold = 1;
                held = dut_item();
            end
        end
        chk({name, "_completed"}, 64'(finished), 64'd1);
        chk({name, "_srat_idle"}, 64'(srat_rd_idx), 64'd0);
        chk({name, "_prf_idle"}, 64'(prf_rd_idx), 64'd0);
        chk({name, "_mem_idle"}, 64'(mem_rd_addr), 64'd0);
        halt = 1'b0;
    endtask

    task automatic abort_dump();
        bit found;
        found = 0;
        dump_ready = 1'b1;
        halt = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            halt = 1'b0;
            if (mem_rd_addr == 2'd2) begin
                found = 1;
                break;
            end
        end
        chk("abort_reached_mem2", 64'(found), 64'd1);
        rst = 1'b0;
        #1;
        chk("abort_valid", 64'(dump_valid), 64'd0);
        chk("abort_item", dut_item(), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(dump_done), 64'd0);
        chk("abort_mem_addr", 64'(mem_rd_addr), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_directed();
        for (int p = 0; p < 32; p++) prf_tab[p] = 16'hDE00 ^ 16'(p);
        for (int r = 0; r < 8; r++) begin
            srat_tab[r]     = 5'(8 + r);
            prf_tab[8 + r]  = 16'(16'h0011 * r);
        end
        for (int m = 0; m < 4; m++) mem_tab[m] = 16'(16'h00A0 + m);
    endtask

    task automatic load_random();
        for (int p = 0; p < 32; p++) prf_tab[p] = 16'($urandom);
        for (int r = 0; r < 8; r++) srat_tab[r] = 5'($urandom_range(31, 0));
        for (int m = 0; m < 4; m++) mem_tab[m] = 16'($urandom);
    endtask

    initial begin
        rst = 1'b0;
        halt = 1'b0;
        dump_ready = 1'b1;
        load_directed();

        @(negedge clk);
        chk("rst_valid", 64'(dump_valid), 64'd0);
        chk("rst_item", dut_item(), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(dump_done), 64'd0);
        do_reset();
        repeat (3) @(negedge clk);
        chk("idle_valid", 64'(dump_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_srat", 64'(srat_rd_idx), 64'd0);

        run_dump("ready1", 0, 1'b0);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        repeat (10) @(negedge clk);
        chk("halt_after_done_done", 64'(dump_done), 64'd1);
        chk("halt_after_done_valid", 64'(dump_valid), 64'd0);
        chk("halt_after_done_busy", 64'(busy), 64'd0);

        do_reset();
        run_dump("toggle", 1, 1'b1);

        do_reset();
        run_dump("stall20", 3, 1'b0);

        do_reset();
        abort_dump();
        run_dump("after_abort", 0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            load_random();
            do_reset();
            run_dump("random", 2, 1'(k & 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
